// File: rtl/shift_pulse_ctrl.sv
// shift_pulse_ctrl: sequencer for the shift-right LED bar. It issues one
// Reconfigure pulse to refill the bar, then a Shift_right pulse every
// TICK_DIV+1 cycles until the bar reports LED_timeout or stop is seen.
// Optional feature macro: SHIFT_PAUSE_EN (adds the pause input, which
// freezes the interval divider while in WAIT).
module shift_pulse_ctrl #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       LED_timeout,
`ifdef SHIFT_PAUSE_EN
  input  logic       pause,
`endif
  output logic       Reconfigure,
  output logic       Shift_right,
  output logic       busy,
  output logic       done,
  output logic [3:0] shift_count
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RECONF  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PULSE   = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DIV_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] DIV_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [3:0]       CNT_MAX  = 4'd15;

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] div_r;
  logic [CNT_W-1:0] div_s;
  logic [3:0]       count_s;
  logic             done_s;
  logic             pause_s;

`ifdef SHIFT_PAUSE_EN
  assign pause_s = pause;
`else
  assign pause_s = 1'b0;
`endif

  // Next-state, divider, pulse counter and done-flag decisions.
  always_comb begin
    state_s = state_r;
    div_s   = div_r;
    count_s = shift_count;
    done_s  = done;
    case (state_r)
      ST_IDLE: begin
        if (stop) begin
          state_s = ST_IDLE;
        end else if (start) begin
          state_s = ST_RECONF;
          div_s   = DIV_ZERO;
          count_s = 4'd0;
          done_s  = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RECONF: begin
        div_s = DIV_ZERO;
        if (stop) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (stop) begin
          state_s = ST_IDLE;
          div_s   = DIV_ZERO;
        end else if (LED_timeout) begin
          // The bar has drained: timeout wins over a coincident tick.
          state_s = ST_TIMEOUT;
          div_s   = DIV_ZERO;
          done_s  = 1'b1;
        end else if (pause_s) begin
          div_s = div_r;
        end else if (div_r == DIV_LAST) begin
          state_s = ST_PULSE;
          div_s   = DIV_ZERO;
        end else begin
          div_s = div_r + DIV_ONE;
        end
      end
      ST_PULSE: begin
        // The pulse of this cycle is counted even when stop aborts the session.
        if (shift_count != CNT_MAX) begin
          count_s = shift_count + 4'd1;
        end else begin
          count_s = shift_count;
        end
        if (stop) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_TIMEOUT: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        div_s   = DIV_ZERO;
      end
    endcase
  end

  // State, divider and registered Moore outputs (decoded from next state).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      div_r       <= DIV_ZERO;
      shift_count <= 4'd0;
      done        <= 1'b0;
      Reconfigure <= 1'b0;
      Shift_right <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_r     <= state_s;
      div_r       <= div_s;
      shift_count <= count_s;
      done        <= done_s;
      Reconfigure <= (state_s == ST_RECONF);
      Shift_right <= (state_s == ST_PULSE);
      busy        <= (state_s == ST_RECONF) || (state_s == ST_WAIT) ||
                     (state_s == ST_PULSE);
    end
  end

endmodule

// File: tb/tb_shift_pulse_ctrl.sv
// tb_shift_pulse_ctrl: directed and randomized bench for shift_pulse_ctrl.
// Includes a small LED bar model (refill to 0x3FF, shift right, timeout on
// a shift of an empty bar) and a schedule-based reference for the outputs.
module tb_shift_pulse_ctrl;
  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       LED_timeout;
  logic       pz;
  logic       Reconfigure;
  logic       Shift_right;
  logic       busy;
  logic       done;
  logic [3:0] shift_count;

  shift_pulse_ctrl #(.TICK_DIV(TD), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .LED_timeout(LED_timeout),
`ifdef SHIFT_PAUSE_EN
    .pause      (pz),
`endif
    .Reconfigure(Reconfigure),
    .Shift_right(Shift_right),
    .busy       (busy),
    .done       (done),
    .shift_count(shift_count)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Reference schedule: a session is open, when its Reconfigure falls,
  // when the next Shift_right is due, and when the timeout cycle was.
  bit m_sess = 1'b0;
  bit m_done = 1'b0;
  int m_cnt = 0;
  int m_reconf_at = -100;
  int m_pulse_at = -100;
  int m_tout_at = -100;

  // LED bar model
  logic [9:0] bar = 10'd0;
  bit inj_next = 1'b0;

  int pulse_log[$];
  int reconf_log[$];
  int done_rise = -1;
  int busy_fall = -1;
  logic prev_done = 1'b0;
  logic prev_busy = 1'b0;
  int base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    bit s_rst, s_start, s_stop, s_to, s_pause, rc, sr, to_n, was_pulse, was_wait;
    int p;
    if (chk_en) begin
      chk("Reconfigure", {31'd0, Reconfigure}, {31'd0, (m_sess && cyc == m_reconf_at)});
      chk("Shift_right", {31'd0, Shift_right}, {31'd0, (m_sess && cyc == m_pulse_at)});
      chk("busy", {31'd0, busy}, {31'd0, m_sess});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("shift_count", {28'd0, shift_count}, m_cnt);
    end
    rc = (Reconfigure === 1'b1);
    sr = (Shift_right === 1'b1);
    if (sr) pulse_log.push_back(cyc);
    if (rc) reconf_log.push_back(cyc);
    if (done === 1'b1 && prev_done !== 1'b1) done_rise = cyc;
    if (busy === 1'b0 && prev_busy === 1'b1) busy_fall = cyc;
    prev_done = done;
    prev_busy = busy;
    s_rst = rst; s_start = start; s_stop = stop; s_to = LED_timeout; s_pause = pz;
    @(posedge clk);
    #1;
    cyc++;
    chk_en = 1'b1;
    // LED bar reacts to the commands seen in the cycle just ended
    to_n = 1'b0;
    if (rc) bar = 10'h3FF;
    else if (sr) begin
      if (bar == 10'd0) to_n = 1'b1;
      else bar = bar >> 1;
    end
    LED_timeout = to_n | inj_next;
    // Reference update for the edge just taken
    p = cyc - 1;
    if (!s_rst) begin
      m_sess = 1'b0; m_done = 1'b0; m_cnt = 0; m_tout_at = -100;
    end else if (p == m_tout_at) begin
      m_sess = 1'b0;
    end else if (!m_sess) begin
      if (s_start && !s_stop) begin
        m_sess = 1'b1; m_done = 1'b0; m_cnt = 0;
        m_reconf_at = cyc;
        m_pulse_at = cyc + 1 + TD;
      end
    end else begin
      was_pulse = (p == m_pulse_at);
      was_wait = !was_pulse && (p != m_reconf_at);
      if (was_pulse && m_cnt < 15) m_cnt++;
      if (s_stop) m_sess = 1'b0;
      else if (was_wait && s_to) begin
        m_sess = 1'b0; m_done = 1'b1; m_tout_at = cyc;
      end else if (was_pulse) m_pulse_at = cyc + TD;
      else if (was_wait && s_pause) m_pulse_at++;
    end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic clear_logs();
    pulse_log.delete();
    reconf_log.delete();
    done_rise = -1;
    busy_fall = -1;
  endtask

  initial begin
    rst = 1'b0; start = 1'b1; stop = 1'b0; pz = 1'b0; LED_timeout = 1'b0;

    // Reset held three cycles with start high
    step(); step(); step();
    chk("rst_outputs", {27'd0, Reconfigure, Shift_right, busy, done, shift_count}, 32'd0);
    rst = 1'b1;
    step();
    chk("rst_release_reconf", {31'd0, Reconfigure}, 32'd1);
    start = 1'b0; stop = 1'b1;
    step();
    stop = 1'b0;
    run_to(cyc + 3);

    // Full session with the bar draining to timeout
    clear_logs();
    start = 1'b1; base = cyc;
    step();
    start = 1'b0;
    run_to(base + 62);
    chk("full_npulses", pulse_log.size(), 32'd11);
    for (int i = 0; i < 11 && i < pulse_log.size(); i++)
      chk("full_pulse_time", pulse_log[i] - base, 6 + 5 * i);
    chk("full_reconf_time", reconf_log.size() > 0 ? reconf_log[0] - base : -1, 32'd1);
    chk("full_count", {28'd0, shift_count}, 32'd11);
    chk("full_bar", {22'd0, bar}, 32'd0);
    chk("full_done_rise", done_rise - base, 32'd58);
    chk("full_busy_fall", busy_fall - base, 32'd58);

    // Restart after done, then abort at cycle 20
    clear_logs();
    start = 1'b1; base = cyc;
    step();
    start = 1'b0;
    chk("restart_done_clear", {31'd0, done}, 32'd0);
    chk("restart_count_clear", {28'd0, shift_count}, 32'd0);
    step();
    chk("restart_bar_refill", {22'd0, bar}, 32'h3FF);
    run_to(base + 20);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_count", {28'd0, shift_count}, 32'd3);
    run_to(base + 40);
    chk("abort_npulses", pulse_log.size(), 32'd3);
    for (int i = 0; i < pulse_log.size(); i++)
      chk("abort_pulse_time", pulse_log[i] - base, 6 + 5 * i);

    // Start pulses during a session are ignored
    clear_logs();
    start = 1'b1; base = cyc;
    step();
    start = 1'b0;
    run_to(base + 3);
    start = 1'b1; step(); start = 1'b0;
    run_to(base + 30);
    start = 1'b1; step(); start = 1'b0;
    run_to(base + 62);
    chk("ign_npulses", pulse_log.size(), 32'd11);
    for (int i = 0; i < 11 && i < pulse_log.size(); i++)
      chk("ign_pulse_time", pulse_log[i] - base, 6 + 5 * i);
    chk("ign_nreconf", reconf_log.size(), 32'd1);

`ifdef SHIFT_PAUSE_EN
    // Pause during cycles 7-16, then stop while paused
    clear_logs();
    start = 1'b1; base = cyc;
    step();
    start = 1'b0;
    run_to(base + 7);
    pz = 1'b1;
    run_to(base + 17);
    pz = 1'b0;
    run_to(base + 28);
    pz = 1'b1;
    step();
    stop = 1'b1;
    step();
    stop = 1'b0; pz = 1'b0;
    chk("pause_stop_busy", {31'd0, busy}, 32'd0);
    run_to(base + 40);
    chk("pause_npulses", pulse_log.size(), 32'd3);
    if (pulse_log.size() == 3) begin
      chk("pause_p1", pulse_log[0] - base, 32'd6);
      chk("pause_p2", pulse_log[1] - base, 32'd21);
      chk("pause_p3", pulse_log[2] - base, 32'd26);
    end
`endif

    // Randomized traffic checked against the reference schedule
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) != 0);
      start = ($urandom_range(0, 5) == 0);
      stop = ($urandom_range(0, 39) == 0);
`ifdef SHIFT_PAUSE_EN
      pz = ($urandom_range(0, 3) == 0);
`endif
      inj_next = ($urandom_range(0, 59) == 0);
      step();
    end
    rst = 1'b1; start = 1'b0; stop = 1'b1; pz = 1'b0; inj_next = 1'b0;
    step(); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/shift_pulse_ctrl.md
# shift_pulse_ctrl

Sequencer that drives the shift-right LED bar register. It issues a one-cycle `Reconfigure` to refill the bar, then emits single-cycle `Shift_right` pulses at a programmable interval. It watches the bar's `LED_timeout` return and ends the session when the bar has drained. It sits between the user-control logic (start/stop buttons, already debounced) and the LED bar block, and is the initiator side of that block's `Reconfigure`/`Shift_right`/`LED_timeout` interface.

## Interface
- `TICK_DIV`, default 50000000: clock cycles spent in WAIT between pulses. Minimum 2.
- `CNT_W`, default 26: divider width. Must satisfy 2^CNT_W > TICK_DIV.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  level, sampled each cycle; begins a session from IDLE.
- `stop`  in  1  level; aborts any session.
- `LED_timeout`  in  1  timeout return from the LED bar block.
- `Reconfigure`  out  1  refill command to the LED bar; one-cycle pulse.
- `Shift_right`  out  1  shift command to the LED bar; one-cycle pulse.
- `busy`  out  1  high in RECONF, WAIT and PULSE.
- `done`  out  1  session ended by timeout; sticky until the next accepted start.
- `shift_count`  out  4  pulses issued this session; saturates at 15.
- `pause`  in  1  present only with `SHIFT_PAUSE_EN`. Freezes the interval.

## Operation
- States: IDLE, RECONF, WAIT, PULSE, TIMEOUT. All outputs are Moore decodes of registered state and counters.
  - `Reconfigure` is high only in RECONF.
  - `Shift_right` is high only in PULSE.
- Reset (`rst`=0 at an edge): state IDLE, divider 0, `shift_count` 0, and every output 0. Reset overrides a session in progress with no trailing pulse.
- IDLE: if `start`=1, go to RECONF, clear `done`, `shift_count` and the divider.
- RECONF: always go to WAIT next cycle; divider 0.
- WAIT:
  - divider increments each cycle.
  - When divider == TICK_DIV-1, set divider to 0 and go to PULSE.
  - If `LED_timeout`=1, go to TIMEOUT; this takes precedence over the tick.
- PULSE: `shift_count` += 1 (saturating at 15); go to WAIT.
- TIMEOUT: set `done`=1; go to IDLE next cycle.
- Priority in any state other than IDLE: `stop` > `LED_timeout` > tick.
  - `stop`=1 goes to IDLE next cycle with `done` unchanged (0). No further `Reconfigure` or `Shift_right` is issued.
- `start` outside IDLE is ignored. `start` and `stop` both high in IDLE: `stop` wins and the state stays IDLE.
- `LED_timeout` outside WAIT is ignored.
- A full drain takes 11 pulses: 10 shift the bar from 0x3FF to 0, and the 11th produces `LED_timeout`.

## Timing
- `start` sampled high in cycle k (IDLE):
  - RECONF in cycle k+1.
  - WAIT occupies cycles k+2 … k+1+TICK_DIV.
  - First `Shift_right` in cycle k+2+TICK_DIV.
- Pulse period is TICK_DIV+1 cycles. Pulse n (n≥1) falls in cycle k+2+TICK_DIV+(n-1)(TICK_DIV+1).
- `LED_timeout` arrives in the cycle after pulse 11, which is a WAIT cycle. TIMEOUT follows in the next cycle, then IDLE, with `done`=1 from the TIMEOUT cycle onward.
- `stop` sampled in cycle j: outputs are idle in cycle j+1.
  - A pulse in cycle j itself still completes.

## Configuration
- `SHIFT_PAUSE_EN` defined:
  - The `pause` port exists.
  - While `pause`=1 in WAIT, the divider holds and PULSE is not entered.
  - `stop` and `LED_timeout` still act during pause.
  - `pause` has no effect in other states.
- `SHIFT_PAUSE_EN` not defined: no `pause` port; the divider always runs in WAIT.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `start`=1 → all outputs 0, state IDLE; after release with `start`=1, `Reconfigure` is high exactly one cycle later.
- Full session, TICK_DIV=4, bench models the LED bar:
  - `start` in cycle 0.
  - `Reconfigure` in cycle 1.
  - `Shift_right` in cycles 6, 11, … 56.
  - `shift_count`=11, bar = 0.
  - `done` rises in cycle 58; `busy` falls the same cycle.
- Abort: `stop`=1 in cycle 20 of the above session → no `Shift_right` after cycle 20, `done`=0, `busy`=0 in cycle 21, `shift_count`=3.
- Ignored start: pulse `start` at cycles 3 and 30 during a session → pulse times are unchanged, and `Reconfigure` occurs only in cycle 1.
- Restart: `start` after `done`=1 → `done` clears in the RECONF cycle, `shift_count`=0, and the bar is refilled to 0x3FF.
- With `SHIFT_PAUSE_EN`, TICK_DIV=4: `pause`=1 during cycles 7–16 → pulses land at 6, then 21, 26, …; a `stop` during pause returns to IDLE next cycle.
